cipher_round: RTL and testbench
===============================

// Module: cipher_round
// PURPOSE
//  Iterative AES-128 encryption datapath: one round per clock, 128-bit state register.
//  The round-key stream (key 0..R) comes from an external key-expansion block.
//  roundnum tells the key block which round key to drive on cipher_key.
//  Sits between the key scheduler and the block-cipher output register.
// PARAMETERS
//  N  128  data/key width in bits; only 128 is supported
//  R  10   number of AES rounds; roundnum width is $clog2(R) (4 bits for R=10)
// PORTS
//  clk          in   1     rising-edge clock
//  rst          in   1     synchronous active-high reset
//  plain_text   in   N     plaintext block; sampled only in the round-0 cycle
//  cipher_key   in   N     round key for the round currently shown on roundnum
//  cipher_text  out  N     registered ciphertext of the last completed block
//  roundnum     out  4     current round index, 0..R
// BEHAVIOUR
//  - Byte order: bits [127:120] = byte 0 (s0,0), column-major as in FIPS-197.
//  - Reset (rst=1 at posedge): roundnum=0, state=0, cipher_text=0. Reset applied
//    mid-block aborts that block; no partial result reaches cipher_text.
//  - The sequencer runs freely after reset, with no start or valid handshake.
//    Each posedge advances roundnum 0,1,...,R, then wraps to 0 and starts a new block.
//  - Cycle with roundnum==0: state <= plain_text ^ cipher_key (initial AddRoundKey).
//  - roundnum 1..R-1: state <= MixColumns(ShiftRows(SubBytes(state))) ^ cipher_key.
//  - roundnum==R: final = ShiftRows(SubBytes(state)) ^ cipher_key, with no MixColumns.
//    cipher_text <= final at that edge. cipher_text holds until the next block completes.
//  - Latency: the block started at the roundnum==0 edge appears on cipher_text after
//    the roundnum==R edge, i.e. R+1 edges later (11 for R=10). Throughput: 1 block per R+1 clocks.
//  - SubBytes: combinational 256-entry S-box, 16 instances.
//  - MixColumns: GF(2^8) xtime with reduction polynomial 0x11B.
//  - Inputs are sampled only at posedge. Changes between edges have no effect.
//  - Values of roundnum above R cannot be reached. If one occurs, the next edge forces roundnum=0.
// CONFIGURATION
//  CIPHER_ROUND_DONE_EN defined: adds output port done (1 bit, reset 0).
//    done is high for exactly the one cycle following each cipher_text update.
//  CIPHER_ROUND_DONE_EN undefined: no done port; all other behaviour is identical.
// TESTING
//  1. Stallings vector. Stimulus:
//     plain_text = 0123456789abcdeffedcba9876543210
//     key0 = 0f1571c947d9e8590cb7add6af7f6798, then keys 1..10 (dc9037b0.. through b48ef352..),
//     each driven while roundnum shows its index.
//     Required: cipher_text = ff0b844a0853bf7c6934ab4364148fb9 after the round-10 edge.
//  2. FIPS-197 C.1. Stimulus: pt = 00112233445566778899aabbccddeeff,
//     key 000102..0f expanded by the bench model.
//     Required: cipher_text = 69c4e0d86a7b0430d8cdb78070b4c55a.
//  3. Reset checks:
//     - after rst, roundnum==0 and cipher_text==0;
//     - asserting rst at roundnum==5 returns roundnum to 0 and leaves cipher_text unchanged (0);
//     - a restarted block then completes correctly.
//  4. Back-to-back blocks: vector 1, then vector 2 immediately on the roundnum wrap.
//     Required: both results correct; cipher_text holds each result for exactly 11 cycles.
//  5. Sequencing: roundnum steps 0..10 and wraps to 0.
//     plain_text changed at roundnum!=0 does not affect the result.
//     With CIPHER_ROUND_DONE_EN, done pulses once per block, one cycle after the cipher_text update.

Source files
------------

// File: rtl/cipher_round.sv
// Iterative AES-128 encryption round datapath: one round per clock, free-running round sequencer.
// Optional macro CIPHER_ROUND_DONE_EN adds a one-cycle done pulse after each cipher_text update.
module cipher_round #(
    parameter int N = 128,
    parameter int R = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         plain_text,
    input  logic [N-1:0]         cipher_key,
    output logic [N-1:0]         cipher_text,
    output logic [$clog2(R)-1:0] roundnum
`ifdef CIPHER_ROUND_DONE_EN
    ,
    output logic                 done
`endif
);

    localparam int RW = $clog2(R);
    localparam logic [RW-1:0] LAST = RW'(R);

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[(255 - int'(x)) * 8 +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte i = row r + 4*col c sits at bits [N-1-8i -: 8]; ShiftRows pulls row r from column (c+r)%4.
    function automatic logic [N-1:0] sub_shift(input logic [N-1:0] s);
        logic [N-1:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[N-1-8*(r+4*c) -: 8] = sbox(s[N-1-8*(r+4*((c+r)%4)) -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [N-1:0] mix_columns(input logic [N-1:0] s);
        logic [N-1:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[N-1-32*c -: 8];
            a1 = s[N-9-32*c -: 8];
            a2 = s[N-17-32*c -: 8];
            a3 = s[N-25-32*c -: 8];
            o[N-1-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                 a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                 a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                 xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        return o;
    endfunction

    logic [RW-1:0] round_q, round_d;
    logic [N-1:0]  state_q, state_d;
    logic [N-1:0]  ct_q, ct_d;
    logic [N-1:0]  sr_w, mc_w;

    assign sr_w = sub_shift(state_q);
    assign mc_w = mix_columns(sr_w);

    // Out-of-range round values fall into the final branch and are forced back to 0.
    always_comb begin
        round_d = round_q;
        state_d = state_q;
        ct_d    = ct_q;
        if (round_q == '0) begin
            state_d = plain_text ^ cipher_key;
            round_d = round_q + 1'b1;
        end else if (round_q < LAST) begin
            state_d = mc_w ^ cipher_key;
            round_d = round_q + 1'b1;
        end else begin
            round_d = '0;
            if (round_q == LAST) begin
                ct_d = sr_w ^ cipher_key;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            round_q <= '0;
            state_q <= '0;
            ct_q    <= '0;
        end else begin
            round_q <= round_d;
            state_q <= state_d;
            ct_q    <= ct_d;
        end
    end

    assign cipher_text = ct_q;
    assign roundnum    = round_q;

`ifdef CIPHER_ROUND_DONE_EN
    logic done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            done_q <= 1'b0;
        end else begin
            done_q <= (round_q == LAST);
        end
    end

    assign done = done_q;
`endif

endmodule

// File: tb/tb_cipher_round.sv
// Directed bench for cipher_round: Stallings and FIPS-197 C.1 vectors, reset abort, back-to-back blocks.
// Define CIPHER_ROUND_DONE_EN for both files to also check the done pulse.
module tb_cipher_round;

  localparam logic [127:0] PT_S  = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] KEY_S = 128'h0f1571c947d9e8590cb7add6af7f6798;
  localparam logic [127:0] EXP_S = 128'hff0b844a0853bf7c6934ab4364148fb9;
  localparam logic [127:0] PT_F  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_F = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] EXP_F = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  localparam logic [2047:0] TB_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic         clk;
  logic         rst;
  logic [127:0] plain_text;
  logic [127:0] cipher_key;
  logic [127:0] cipher_text;
  logic [3:0]   roundnum;
`ifdef CIPHER_ROUND_DONE_EN
  logic         done;
`endif

  int tests;
  int fails;
  logic [127:0] rks[2][11];

  cipher_round dut (
    .clk        (clk),
    .rst        (rst),
    .plain_text (plain_text),
    .cipher_key (cipher_key),
    .cipher_text(cipher_text),
    .roundnum   (roundnum)
`ifdef CIPHER_ROUND_DONE_EN
    ,
    .done       (done)
`endif
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] tb_sbox(input logic [7:0] x);
    return TB_SBOX[(255 - int'(x)) * 8 +: 8];
  endfunction

  // AES-128 key expansion into rks[slot][0..10]
  task automatic load_key(input logic [127:0] k, input int slot);
    logic [31:0] w[44];
    logic [31:0] t;
    logic [7:0]  rcon[10];
    rcon = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {tb_sbox(t[31:24]), tb_sbox(t[23:16]), tb_sbox(t[15:8]), tb_sbox(t[7:0])};
        t = t ^ {rcon[i/4-1], 24'h0};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rks[slot][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // driver: one full block; plain_text is scrambled on every non-zero round
  task automatic run_block(input logic [127:0] pt, input int slot, input logic [127:0] exp_ct,
                           input logic [127:0] prev_ct, input logic prev_done, input string tag);
    for (int r = 0; r < 11; r++) begin
      check($sformatf("%s rn%0d", tag, r), {124'b0, roundnum}, 128'(r));
      check($sformatf("%s hold%0d", tag, r), cipher_text, prev_ct);
`ifdef CIPHER_ROUND_DONE_EN
      check($sformatf("%s done%0d", tag, r), {127'b0, done}, {127'b0, (r == 0) && prev_done});
`endif
      plain_text = (r == 0) ? pt : {$urandom(), $urandom(), $urandom(), $urandom()};
      cipher_key = rks[slot][r];
      @(posedge clk);
      @(negedge clk);
    end
    check({tag, " result"}, cipher_text, exp_ct);
  endtask

  initial begin
    tests      = 0;
    fails      = 0;
    rst        = 1'b1;
    plain_text = '0;
    cipher_key = '0;
    load_key(KEY_S, 0);
    load_key(KEY_F, 1);
    check("stallings key1", rks[0][1], 128'hdc9037b09b49dfe997fe723f388115a7);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset rn", {124'b0, roundnum}, 128'd0);
    check("reset ct", cipher_text, 128'd0);
`ifdef CIPHER_ROUND_DONE_EN
    check("reset done", {127'b0, done}, 128'd0);
`endif

    // partial block aborted by reset at round 5
    rst = 1'b0;
    for (int r = 0; r < 5; r++) begin
      check($sformatf("abort rn%0d", r), {124'b0, roundnum}, 128'(r));
      plain_text = PT_F;
      cipher_key = rks[1][r];
      @(posedge clk);
      @(negedge clk);
    end
    check("abort rn5", {124'b0, roundnum}, 128'd5);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort rn after rst", {124'b0, roundnum}, 128'd0);
    check("abort ct after rst", cipher_text, 128'd0);
    rst = 1'b0;

    run_block(PT_S, 0, EXP_S, 128'd0, 1'b0, "stallings");
    run_block(PT_F, 1, EXP_F, EXP_S, 1'b1, "fips");
    run_block(PT_S, 0, EXP_S, EXP_F, 1'b1, "stallings2");

    check("wrap rn", {124'b0, roundnum}, 128'd0);
`ifdef CIPHER_ROUND_DONE_EN
    check("final done", {127'b0, done}, 128'd1);
    @(posedge clk);
    @(negedge clk);
    check("final done low", {127'b0, done}, 128'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
